// File: rtl/ahb_master_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl_pkg
//   Shared AHB burst definitions for the master request controller:
//   - hburst_type : AHB HBURST encoding
//   - burst_beats : number of beats a command will transfer
//   - burst_wrap_mask : address bits that take part in the +4 beat step
// ---------------------------------------------------------------------------
package ahb_master_req_ctrl_pkg;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  // Widest address the wrap mask covers; users slice it down to ADDR_W.
  localparam int unsigned MASK_W = 64;

  // Beat count for a burst. cmd_len only matters for undefined-length INCR.
  function automatic logic [4:0] burst_beats(input hburst_type burst,
                                             input logic [3:0] len);
    logic [4:0] beats;
    case (burst)
      HB_SINGLE:           beats = 5'd1;
      HB_INCR:             beats = {1'b0, len} + 5'd1;
      HB_WRAP4, HB_INCR4:  beats = 5'd4;
      HB_WRAP8, HB_INCR8:  beats = 5'd8;
      default:             beats = 5'd16;
    endcase
    return beats;
  endfunction

  // 1 = bit advances with the beat step, 0 = bit is held.
  // WRAPn keeps everything above the 4n-byte window fixed.
  function automatic logic [MASK_W-1:0] burst_wrap_mask(input hburst_type burst);
    logic [MASK_W-1:0] mask;
    case (burst)
      HB_WRAP4:  mask = MASK_W'(64'h0F);
      HB_WRAP8:  mask = MASK_W'(64'h1F);
      HB_WRAP16: mask = MASK_W'(64'h3F);
      default:   mask = '1;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl_addr_gen
//   Combinational next-beat address: +4, wrapping inside the burst window
//   for WRAPn bursts and wrapping around ADDR_W for linear bursts.
// Ports
//   addr_i   current beat address
//   burst_i  burst type of the transfer in flight
//   addr_o   address of the following beat
// ---------------------------------------------------------------------------
module ahb_master_req_ctrl_addr_gen
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  hburst_type        burst_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [MASK_W-1:0] mask_full;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] addr_inc;

  assign mask_full = burst_wrap_mask(burst_i);
  assign mask      = mask_full[ADDR_W-1:0];
  assign addr_inc  = addr_i + ADDR_W'(4);

  // Held bits come from the current address, stepping bits from the sum,
  // so the carry out of the window is simply discarded.
  assign addr_o = (addr_i & ~mask) | (addr_inc & mask);

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl
//   Master-side request/burst controller. Takes one command from the master
//   core, requests the slave arbiter, counts granted beats, steps the address
//   and releases the request after the last beat. Gives up with timeout_err
//   if no first grant arrives within TIMEOUT_CYC request cycles.
// Ports
//   hclk, hreset_n         clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_burst/len/prior/addr  command fields
//   hreq, hburst, hprior   request toward the arbiter
//   hgrant                 beat accepted this cycle (already gated by ~hwait)
//   haddr                  address of the current beat
//   beat_en, beat_last     beat strobe and final-beat flag
//   done, timeout_err      registered single-cycle completion / abort pulses
// ---------------------------------------------------------------------------
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned PRIOR_LEVEL = 2,
  parameter int unsigned PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  hburst_type           cmd_burst,
  input  logic [3:0]           cmd_len,
  input  logic [PRIOR_BIT-1:0] cmd_prior,
  input  logic [ADDR_W-1:0]    cmd_addr,
  output logic                 hreq,
  output hburst_type           hburst,
  output logic [PRIOR_BIT-1:0] hprior,
  input  logic                 hgrant,
  output logic [ADDR_W-1:0]    haddr,
  output logic                 beat_en,
  output logic                 beat_last,
  output logic                 done,
  output logic                 timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYC - 1);

  logic [1:0]           state_q,    state_d;
  hburst_type           burst_q,    burst_d;
  logic [PRIOR_BIT-1:0] prior_q,    prior_d;
  logic [ADDR_W-1:0]    addr_q,     addr_d;
  logic [4:0]           beats_q,    beats_d;
  logic [4:0]           beat_cnt_q, beat_cnt_d;
  logic [4:0]           wait_cnt_q, wait_cnt_d;
  logic                 done_q,     done_d;
  logic                 tmo_q,      tmo_d;

  logic [ADDR_W-1:0]    addr_next;
  logic                 in_xfer;
  logic                 is_last;

  ahb_master_req_ctrl_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr_i  (addr_q),
    .burst_i (burst_q),
    .addr_o  (addr_next)
  );

  assign in_xfer = (state_q == ST_REQ) || (state_q == ST_BURST);
  assign is_last = (beat_cnt_q == beats_q - 5'd1);

  assign cmd_ready   = (state_q == ST_IDLE) && hreset_n;
  assign hreq        = in_xfer;
  assign hburst      = burst_q;
  assign hprior      = prior_q;
  assign haddr       = addr_q;
  assign beat_en     = in_xfer && hgrant;
  assign beat_last   = beat_en && is_last;
  assign done        = done_q;
  assign timeout_err = tmo_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    burst_d    = burst_q;
    prior_d    = prior_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          burst_d    = cmd_burst;
          prior_d    = cmd_prior;
          addr_d     = cmd_addr;
          beats_d    = burst_beats(cmd_burst, cmd_len);
          beat_cnt_d = 5'd0;
          wait_cnt_d = 5'd0;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        // A grant in the final wait cycle still counts as beat 0.
        if (hgrant) begin
          if (beats_q == 5'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_cnt_d = 5'd1;
            addr_d     = addr_next;
            state_d    = ST_BURST;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end

      ST_BURST: begin
        if (hgrant) begin
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
            addr_d     = addr_next;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!hreset_n) begin
      state_q    <= ST_IDLE;
      burst_q    <= HB_SINGLE;
      prior_q    <= '0;
      addr_q     <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      prior_q    <= prior_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_req_ctrl
//   Self-checking bench: each command pushes its expected beat addresses to a
//   queue; a negedge monitor pops and compares on every beat_en.
// ---------------------------------------------------------------------------
module tb_ahb_master_req_ctrl;
  import ahb_master_req_ctrl_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [31:0] addr;
    logic        last;
  } beat_t;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  hburst_type  cmd_burst;
  logic [3:0]  cmd_len;
  logic [0:0]  cmd_prior;
  logic [31:0] cmd_addr;
  logic        hreq;
  hburst_type  hburst;
  logic [0:0]  hprior;
  logic        hgrant;
  logic [31:0] haddr;
  logic        beat_en;
  logic        beat_last;
  logic        done;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int beats_seen = 0;
  int done_cnt   = 0;
  int tmo_cnt    = 0;

  beat_t       exp_q[$];
  hburst_type  exp_burst = HB_SINGLE;
  logic [0:0]  exp_prior = '0;

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl #(
    .PRIOR_LEVEL (2),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_burst   (cmd_burst),
    .cmd_len     (cmd_len),
    .cmd_prior   (cmd_prior),
    .cmd_addr    (cmd_addr),
    .hreq        (hreq),
    .hburst      (hburst),
    .hprior      (hprior),
    .hgrant      (hgrant),
    .haddr       (haddr),
    .beat_en     (beat_en),
    .beat_last   (beat_last),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, written independently of the RTL's mask formulation.
  function automatic int model_beats(input hburst_type b, input logic [3:0] len);
    case (b)
      HB_SINGLE:          return 1;
      HB_INCR:            return int'(len) + 1;
      HB_WRAP4, HB_INCR4: return 4;
      HB_WRAP8, HB_INCR8: return 8;
      default:            return 16;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input hburst_type b, input int nb);
    longint unsigned win, base, off;
    if (b == HB_WRAP4 || b == HB_WRAP8 || b == HB_WRAP16) begin
      win  = longint'(4 * nb);
      base = (longint'(a) / win) * win;
      off  = (longint'(a) - base + 4) % win;
      return 32'(base + off);
    end
    return a + 32'd4;
  endfunction

  // Monitor: sampled on the falling edge, away from the driving edge.
  always @(negedge hclk) begin
    if (hreset_n) begin
      check("cmd_ready_vs_hreq", cmd_ready, !hreq);
      if (hreq) begin
        check("hburst_stable", hburst, exp_burst);
        check("hprior_stable", hprior, exp_prior);
      end
      if (beat_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("haddr", haddr, e.addr);
          check("beat_last", beat_last, e.last);
        end
        beats_seen++;
      end else begin
        check("beat_last_no_beat", beat_last, 0);
      end
      if (done)        done_cnt++;
      if (timeout_err) tmo_cnt++;
    end
  end

  // Issue one command, apply a grant pattern (bit i for cycle i, then 1s),
  // and check completion. cycles returns the number of hreq cycles.
  task automatic run_txn(input hburst_type b, input logic [3:0] len, input logic [0:0] pr,
                         input logic [31:0] a, input logic [31:0] pat, input int pat_len,
                         output int cycles);
    int nb, base_beats, base_done, guard;
    logic [31:0] cur;
    nb = model_beats(b, len);
    cur = a;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back('{addr: cur, last: (i == nb - 1)});
      cur = model_next(cur, b, nb);
    end
    exp_burst  = b;
    exp_prior  = pr;
    base_beats = beats_seen;
    base_done  = done_cnt;
    cmd_valid = 1'b1; cmd_burst = b; cmd_len = len; cmd_prior = pr; cmd_addr = a;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    check("hreq_after_cmd", hreq, 1);
    cycles = 0;
    guard  = 0;
    while ((beats_seen - base_beats) < nb && guard < 200) begin
      hgrant = (cycles < pat_len) ? pat[cycles] : 1'b1;
      cycles++;
      guard++;
      @(posedge hclk); #1;
    end
    hgrant = 1'b0;
    check("beat_count", beats_seen - base_beats, nb);
    check("done_pulse", done, 1);
    check("hreq_released", hreq, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("queue_empty", exp_q.size(), 0);
    @(posedge hclk); #1;
    check("done_single_cycle", done, 0);
    check("done_once", done_cnt - base_done, 1);
  endtask

  initial begin
    int cyc, n, d0, t0;
    logic [31:0] pat;

    hreset_n = 1'b0; cmd_valid = 1'b0; cmd_burst = HB_SINGLE; cmd_len = '0;
    cmd_prior = '0; cmd_addr = '0; hgrant = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hreq", hreq, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hburst", hburst, HB_SINGLE);
    check("rst_hprior", hprior, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    hreset_n = 1'b1;
    @(posedge hclk); #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // Grant in IDLE must be ignored (the monitor flags any beat_en).
    hgrant = 1'b1;
    @(posedge hclk); #1;
    hgrant = 1'b0;
    check("idle_grant_hreq", hreq, 0);

    // SINGLE, grant after three waiting cycles: hreq high for 4 cycles.
    pat = 32'h0;
    run_txn(HB_SINGLE, 4'd0, 1'b1, 32'h100, pat, 3, cyc);
    check("single_hreq_cycles", cyc, 4);

    run_txn(HB_INCR4,  4'd0, 1'b0, 32'h10, pat, 0, cyc);
    run_txn(HB_WRAP4,  4'd0, 1'b1, 32'h38, pat, 0, cyc);
    run_txn(HB_WRAP8,  4'd0, 1'b0, 32'h1C, pat, 0, cyc);

    // INCR len=5 with grant pattern 1,0,0,1,1,0,1,1,1 (bit 0 first).
    pat = 32'b1_1101_1001;
    run_txn(HB_INCR, 4'd5, 1'b1, 32'h200, pat, 9, cyc);
    check("incr_hreq_cycles", cyc, 9);

    run_txn(HB_INCR4,  4'd0, 1'b0, 32'hFFFF_FFF8, 32'h0, 0, cyc);
    run_txn(HB_WRAP16, 4'd0, 1'b1, 32'h1234, 32'h0, 0, cyc);
    run_txn(HB_INCR16, 4'd0, 1'b0, 32'h400, 32'h0, 0, cyc);

    // Grant timeout.
    d0 = done_cnt; t0 = tmo_cnt;
    exp_burst = HB_INCR; exp_prior = 1'b1;
    cmd_valid = 1'b1; cmd_burst = HB_INCR; cmd_len = 4'd0; cmd_prior = 1'b1; cmd_addr = 32'h80;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (hreq && n < 40) begin
      n++;
      @(posedge hclk); #1;
    end
    check("tmo_req_cycles", n, TIMEOUT);
    check("tmo_pulse", timeout_err, 1);
    check("tmo_hreq", hreq, 0);
    check("tmo_cmd_ready", cmd_ready, 1);
    check("tmo_no_done", done, 0);
    @(posedge hclk); #1;
    check("tmo_single_cycle", timeout_err, 0);
    check("tmo_once", tmo_cnt - t0, 1);
    check("tmo_no_done_cnt", done_cnt - d0, 0);

    // Reset while beat 3 of an INCR8 is on the bus.
    d0 = done_cnt; t0 = tmo_cnt;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{addr: 32'h40 + 32'(4 * i), last: (i == 7)});
    exp_burst = HB_INCR8; exp_prior = 1'b0;
    cmd_valid = 1'b1; cmd_burst = HB_INCR8; cmd_len = 4'd0; cmd_prior = 1'b0; cmd_addr = 32'h40;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    hgrant = 1'b1;
    n = beats_seen;
    for (int g = 0; g < 50 && (beats_seen - n) < 3; g++) begin
      @(posedge hclk); #1;
    end
    check("pre_reset_beats", beats_seen - n, 3);
    check("pre_reset_haddr", haddr, 32'h4C);
    hreset_n = 1'b0;
    @(posedge hclk); #1;
    hgrant = 1'b0;
    check("mid_rst_hreq", hreq, 0);
    check("mid_rst_haddr", haddr, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    hreset_n = 1'b1;
    @(posedge hclk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_done", done, 0);
    check("post_rst_timeout", timeout_err, 0);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_no_tmo", tmo_cnt - t0, 0);
    run_txn(HB_SINGLE, 4'd0, 1'b1, 32'h300, 32'h0, 1, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
